// File: rtl/freq_meter_if.sv
// Signal bundle for freq_meter: measurement enable, measured input and result outputs.
interface freq_meter_if #(
  parameter int CNT_W = 26
);
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] freq_hz;
  logic             freq_valid;
  logic             ovf;
  logic             busy;

  modport master (
    output en,
    output sig_in,
    input  freq_hz,
    input  freq_valid,
    input  ovf,
    input  busy
  );

  modport slave (
    input  en,
    input  sig_in,
    output freq_hz,
    output freq_valid,
    output ovf,
    output busy
  );
endinterface

// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronized rising edges of sig_in over GATE_CYC clk cycles.
// Optional glitch filter on the synchronized input: define FREQ_METER_GLITCH_FILTER_EN.
module freq_meter #(
  parameter int GATE_CYC = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  freq_meter_if.slave  bus
);
  localparam int             GW        = (GATE_CYC > 2) ? $clog2(GATE_CYC) : 1;
  localparam logic [GW-1:0]  GATE_LAST = GW'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_GATE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             sat_q, sat_d, sat_now;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             sync1_q, sync2_q;
  logic             prev_q, edge_q;
  logic             lvl;

`ifdef FREQ_METER_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;

  // Filter history: the level is accepted once three consecutive synchronized samples agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 2'b00;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync2_q};
      filt_q <= lvl;
    end
  end

  // Filtered level: follow the synchronizer only when it has been stable for three samples.
  always_comb begin
    lvl = filt_q;
    if ((sync2_q == hist_q[0]) && (sync2_q == hist_q[1])) begin
      lvl = sync2_q;
    end else begin
      lvl = filt_q;
    end
  end
`else
  // Unfiltered level straight from the synchronizer.
  always_comb begin
    lvl = sync2_q;
  end
`endif

  // Synchronizer and rising-edge register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= bus.sig_in;
      sync2_q <= sync1_q;
      prev_q  <= lvl;
      edge_q  <= lvl & ~prev_q;
    end
  end

  // Saturating edge accumulation for the current cycle.
  always_comb begin
    cnt_inc = cnt_q;
    sat_now = sat_q;
    if (edge_q) begin
      if (cnt_q == CNT_MAX) begin
        sat_now = 1'b1;
      end else begin
        cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_inc = cnt_q;
    end
  end

  // Gate FSM next state, counters and result capture.
  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    freq_d  = freq_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        gate_d = {GW{1'b0}};
        cnt_d  = {CNT_W{1'b0}};
        sat_d  = 1'b0;
        if (bus.en) begin
          state_d = S_GATE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GATE: begin
        // Window end wins over a simultaneous drop of en so the finished window still reports.
        if (gate_q == GATE_LAST) begin
          freq_d  = cnt_inc;
          ovf_d   = sat_now;
          valid_d = 1'b1;
          gate_d  = {GW{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          sat_d   = 1'b0;
          if (bus.en) begin
            state_d = S_GATE;
          end else begin
            state_d = S_IDLE;
          end
        end else if (!bus.en) begin
          state_d = S_IDLE;
          gate_d  = {GW{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          sat_d   = 1'b0;
        end else begin
          gate_d = gate_q + {{(GW-1){1'b0}}, 1'b1};
          cnt_d  = cnt_inc;
          sat_d  = sat_now;
        end
      end
      default: begin
        state_d = S_IDLE;
        gate_d  = {GW{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
        sat_d   = 1'b0;
      end
    endcase
    busy_d = (state_d == S_GATE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gate_q  <= {GW{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      sat_q   <= 1'b0;
      freq_q  <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      freq_q  <= freq_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.freq_hz    = freq_q;
  assign bus.ovf        = ovf_q;
  assign bus.freq_valid = valid_q;
  assign bus.busy       = busy_q;
endmodule
